uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side frame buffer placed directly downstream of the UART receiver/register-file module. Captures each received frame (9-bit, as produced by the receiver on `frame` / `frame_valid`) into a small first-word-fall-through FIFO in the system `clk` domain. Downstream logic (VGA command/character path) drains it with a simple read-enable handshake. Overflow is flagged and sticky, so no frame is lost silently.

## Interface

- `DEPTH`, 8, number of frame entries; power of two, 2..64
- `WIDTH`, 9, frame width in bits; matches receiver `frame`
- `clk`  in  1  system clock; all state in this domain
- `rst`  in  1  reset, asynchronous, active-low
- `frame_valid`  in  1  receiver frame-ready level; treated as asynchronous (source is the `clk_16bd` domain)
- `frame`  in  WIDTH  received frame; stable from before `frame_valid` rises until the next frame
- `rd_en`  in  1  consume head entry
- `clr_ovf`  in  1  clear sticky overflow flag
- `rd_data`  out  WIDTH  head entry (valid when `rd_valid`=1, else 0)
- `rd_valid`  out  1  FIFO not empty
- `full`  out  1  count == DEPTH
- `count`  out  log2(DEPTH)+1  entries stored, 0..DEPTH
- `overflow`  out  1  sticky: a frame was dropped because FIFO was full

## Operation

- `frame_valid` passes through a 2-flop synchronizer (s1, s2) plus a third flop s3; write request `wr = s2 & ~s3` (rising edge only). A level held high for any number of cycles yields exactly one write.
- On `wr`: if not full, or full with `rd_en`=1 in the same cycle, `frame` is written at `wr_ptr` and `wr_ptr` increments; otherwise frame dropped and `overflow` set.
- Read: `rd_data = mem[rd_ptr]` combinationally (first-word fall-through). `rd_en`=1 with `rd_valid`=1 advances `rd_ptr`; `rd_en` while empty is ignored (no pointer or count change).
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH naturally; `count` increments on accepted write only, decrements on accepted read only, unchanged on simultaneous accepted read+write.
- Simultaneous write and read when empty: read is ignored (empty at that edge), write accepted; count becomes 1.
- `overflow`: set on a dropped frame; cleared by `clr_ovf`; set wins if both occur in the same cycle.
- Memory array is not reset; only pointers, count, synchronizer flops and `overflow` are.

## Timing

- Reset (`rst`=0, asynchronous): s1/s2/s3=0, pointers=0, `count`=0, `rd_valid`=0, `full`=0, `overflow`=0, `rd_data`=0. Reset mid-operation discards all stored frames; a `frame_valid` already high at reset release produces one write (edge seen by s2/s3 after release).
- Latency: `frame_valid` sampled high at edge k → s2=1 after edge k+1 → write at edge k+2 → `rd_valid`=1, `rd_data`=frame after edge k+2 (2–3 clk cycles depending on async alignment).
- Read: `rd_en` high at edge n pops head; new head (or `rd_valid`=0) visible after edge n.
- `full`, `count`, `rd_valid` are registered/derived from registered state; all change only on `clk` edges (except async reset).
- Minimum `frame_valid` low and high time: 2 `clk` periods each to guarantee edge detection (satisfied since `clk` ≥ `clk_16bd`).

## Test plan

- Single frame: `frame`=9'h0A5, `frame_valid` rises and stays high 20 cycles → exactly one write; `rd_valid`=1 within 3 edges, `rd_data`=9'h0A5, `count`=1; `rd_en` one cycle → `rd_valid`=0, `count`=0, `rd_data`=0.
- Fill + overflow: 9 frames 9'h100..9'h108, no reads → `count`=8, `full`=1, `overflow`=1; reads return 9'h100..9'h107 in order, 9'h108 absent.
- Full with simultaneous read+write: FIFO full, write edge coincides with `rd_en` → frame accepted, `count` stays 8, `overflow` stays 0; pointer wrap verified by reading all 8 in order.
- Empty read: `rd_en`=1 for 5 cycles on empty FIFO → `count`=0, pointers unchanged; then one write reads back correctly.
- Overflow clear priority: `clr_ovf`=1 in same cycle as dropped frame → `overflow`=1; `clr_ovf` next cycle alone → `overflow`=0.
- Reset mid-operation: 5 entries stored, `rst` pulsed low asynchronously between edges → outputs immediately at reset values; after release with `frame_valid`=1, one write occurs, `count`=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive frame buffer: synchronizes the UART frame-ready level, captures one frame
// per rising edge into a first-word-fall-through FIFO, flags dropped frames.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_valid,
    input  logic [WIDTH-1:0]         frame,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             s1, s2, s3;
    logic             overflow_q;
    logic             wr;
    logic             wr_ok;
    logic             rd_ok;

    // frame_valid comes from the clk_16bd domain; s3 only serves edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the three flops a true shift chain;
            // blocking ones would collapse it into a single stage.
            s1 <= frame_valid;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign wr       = s2 & ~s3;
    assign rd_valid = (count_q != '0);
    assign full     = (count_q == FULL_COUNT);
    // A full FIFO still accepts a write when the head is consumed on the same edge.
    assign wr_ok    = wr & (~full | rd_en);
    assign rd_ok    = rd_en & rd_valid;

    // NOTE: the storage array has no reset; pointers and count alone define validity,
    // and leaving it out keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= frame;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - (AW+1)'(1);
            end
            // Setting on a drop takes priority over a simultaneous clear.
            if (wr && !wr_ok) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
